// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the
// Execute/Memory pipeline register with stall (hold) and flush (bubble).
module execute_stage #(
   parameter int unsigned      XLEN           = 32,
   parameter logic [XLEN-1:0]  RESET_PC_PLUS4 = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            RegWriteE,
   input  logic [1:0]      ResultSrcE,
   input  logic            MemWriteE,
   input  logic            JumpE,
   input  logic            JalrE,
   input  logic            BranchE,
   input  logic [2:0]      funct3E,
   input  logic [3:0]      ALUControlE,
   input  logic            ALUSrcAE,
   input  logic            ALUSrcBE,
   input  logic [XLEN-1:0] rs1_data_E,
   input  logic [XLEN-1:0] rs2_data_E,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] immExtE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic [4:0]      RdE,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic [XLEN-1:0] ResultW,
   input  logic            StallM,
   input  logic            FlushM,
   output logic            PCSrcE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            RegWriteM,
   output logic            MemWriteM,
   output logic [1:0]      ResultSrcM,
   output logic [XLEN-1:0] ALUResultM,
   output logic [XLEN-1:0] WriteDataM,
   output logic [XLEN-1:0] PCPlus4M,
   output logic [4:0]      RdM
);

   logic [XLEN-1:0] src_a_fwd, src_b_fwd, src_a, src_b, alu_result_e;
   logic [4:0]      shamt;
   logic            branch_cond;

   logic            reg_write_q, reg_write_d;
   logic            mem_write_q, mem_write_d;
   logic [1:0]      result_src_q, result_src_d;
   logic [XLEN-1:0] alu_result_q, alu_result_d;
   logic [XLEN-1:0] write_data_q, write_data_d;
   logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
   logic [4:0]      rd_q, rd_d;

   // Forwarding muxes; the ALUResultM source is this stage's own registered result.
   always_comb begin
      case (ForwardAE)
         2'b01:   src_a_fwd = ResultW;
         2'b10:   src_a_fwd = alu_result_q;
         default: src_a_fwd = rs1_data_E;
      endcase
      case (ForwardBE)
         2'b01:   src_b_fwd = ResultW;
         2'b10:   src_b_fwd = alu_result_q;
         default: src_b_fwd = rs2_data_E;
      endcase
      src_a = ALUSrcAE ? PCE : src_a_fwd;
      src_b = ALUSrcBE ? immExtE : src_b_fwd;
   end

   // ALU; unused encodings return zero.
   always_comb begin
      shamt = src_b[4:0];
      case (ALUControlE)
         4'b0000: alu_result_e = src_a + src_b;
         4'b0001: alu_result_e = src_a - src_b;
         4'b0010: alu_result_e = src_a & src_b;
         4'b0011: alu_result_e = src_a | src_b;
         4'b0100: alu_result_e = src_a ^ src_b;
         4'b0101: alu_result_e = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         4'b0110: alu_result_e = {{(XLEN-1){1'b0}}, (src_a < src_b)};
         4'b0111: alu_result_e = src_a << shamt;
         4'b1000: alu_result_e = src_a >> shamt;
         4'b1001: alu_result_e = $signed(src_a) >>> shamt;
         4'b1010: alu_result_e = src_b;
         default: alu_result_e = '0;
      endcase
   end

   // Branch condition compares the forwarded registers, never PC/immediate.
   always_comb begin
      case (funct3E)
         3'b000:  branch_cond = (src_a_fwd == src_b_fwd);
         3'b001:  branch_cond = (src_a_fwd != src_b_fwd);
         3'b100:  branch_cond = ($signed(src_a_fwd) < $signed(src_b_fwd));
         3'b101:  branch_cond = ($signed(src_a_fwd) >= $signed(src_b_fwd));
         3'b110:  branch_cond = (src_a_fwd < src_b_fwd);
         3'b111:  branch_cond = (src_a_fwd >= src_b_fwd);
         default: branch_cond = 1'b0;
      endcase
      PCSrcE    = JumpE | (BranchE & branch_cond);
      PCTargetE = JalrE ? {alu_result_e[XLEN-1:1], 1'b0} : (PCE + immExtE);
   end

   // E/M next state: flush beats stall, stall holds, otherwise capture.
   always_comb begin
      reg_write_d  = reg_write_q;
      mem_write_d  = mem_write_q;
      result_src_d = result_src_q;
      alu_result_d = alu_result_q;
      write_data_d = write_data_q;
      pc_plus4_d   = pc_plus4_q;
      rd_d         = rd_q;
      if (FlushM) begin
         reg_write_d  = 1'b0;
         mem_write_d  = 1'b0;
         result_src_d = 2'b00;
         alu_result_d = '0;
         write_data_d = '0;
         pc_plus4_d   = '0;
         rd_d         = '0;
      end else if (!StallM) begin
         reg_write_d  = RegWriteE;
         mem_write_d  = MemWriteE;
         result_src_d = ResultSrcE;
         alu_result_d = alu_result_e;
         write_data_d = src_b_fwd;
         pc_plus4_d   = PCPlus4E;
         rd_d         = RdE;
      end
   end

   // E/M pipeline register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_write_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         result_src_q <= 2'b00;
         alu_result_q <= '0;
         write_data_q <= '0;
         pc_plus4_q   <= RESET_PC_PLUS4;
         rd_q         <= '0;
      end else begin
         reg_write_q  <= reg_write_d;
         mem_write_q  <= mem_write_d;
         result_src_q <= result_src_d;
         alu_result_q <= alu_result_d;
         write_data_q <= write_data_d;
         pc_plus4_q   <= pc_plus4_d;
         rd_q         <= rd_d;
      end
   end

   assign RegWriteM  = reg_write_q;
   assign MemWriteM  = mem_write_q;
   assign ResultSrcM = result_src_q;
   assign ALUResultM = alu_result_q;
   assign WriteDataM = write_data_q;
   assign PCPlus4M   = pc_plus4_q;
   assign RdM        = rd_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: vector table with a scoreboard for the E/M register,
// plus hand-written reset, stall, flush and async-reset sequences.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcAE, ALUSrcBE;
   logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
   logic [2:0]  funct3E;
   logic [3:0]  ALUControlE;
   logic [31:0] rs1_data_E, rs2_data_E, PCE, immExtE, PCPlus4E, ResultW;
   logic [4:0]  RdE;
   logic        StallM, FlushM;
   logic        PCSrcE, RegWriteM, MemWriteM;
   logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
   logic [1:0]  ResultSrcM;
   logic [4:0]  RdM;

   execute_stage dut (
      .clk(clk), .rst_n(rst_n), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
      .MemWriteE(MemWriteE), .JumpE(JumpE), .JalrE(JalrE), .BranchE(BranchE),
      .funct3E(funct3E), .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE),
      .ALUSrcBE(ALUSrcBE), .rs1_data_E(rs1_data_E), .rs2_data_E(rs2_data_E),
      .PCE(PCE), .immExtE(immExtE), .PCPlus4E(PCPlus4E), .RdE(RdE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
      .StallM(StallM), .FlushM(FlushM), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  alu;
      logic        sa, sb;
      logic [1:0]  fa, fb;
      logic [31:0] rs1, rs2, pc, imm, resw;
      logic        br;
      logic [2:0]  f3;
      logic        jmp, jalr, memw;
      logic        e_pcsrc;
      logic [31:0] e_tgt, e_alu, e_wd;
   } vec_t;

   typedef struct {
      logic        regw, memw;
      logic [1:0]  rsrc;
      logic [31:0] alu, wd, pc4;
      logic [4:0]  rd;
   } mexp_t;

   int checks   = 0;
   int failures = 0;
   vec_t  vecs[$];
   mexp_t sb_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic [3:0] alu, input logic sa, input logic sb, input logic [1:0] fa,
      input logic [1:0] fb, input logic [31:0] rs1, input logic [31:0] rs2,
      input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] resw,
      input logic br, input logic [2:0] f3, input logic jmp, input logic jalr,
      input logic memw, input logic e_pcsrc, input logic [31:0] e_tgt,
      input logic [31:0] e_alu, input logic [31:0] e_wd);
      vec_t v;
      v.alu = alu; v.sa = sa; v.sb = sb; v.fa = fa; v.fb = fb;
      v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.imm = imm; v.resw = resw;
      v.br = br; v.f3 = f3; v.jmp = jmp; v.jalr = jalr; v.memw = memw;
      v.e_pcsrc = e_pcsrc; v.e_tgt = e_tgt; v.e_alu = e_alu; v.e_wd = e_wd;
      return v;
   endfunction

   task automatic apply(input vec_t v, input int idx);
      ALUControlE = v.alu; ALUSrcAE = v.sa; ALUSrcBE = v.sb;
      ForwardAE = v.fa; ForwardBE = v.fb;
      rs1_data_E = v.rs1; rs2_data_E = v.rs2; PCE = v.pc; immExtE = v.imm;
      ResultW = v.resw; BranchE = v.br; funct3E = v.f3; JumpE = v.jmp;
      JalrE = v.jalr; MemWriteE = v.memw;
      PCPlus4E = v.pc + 32'd4; RegWriteE = idx[0]; ResultSrcE = idx[1:0];
      RdE = 5'(idx + 1);
   endtask

   initial begin
      mexp_t m;
      // Reset held with random inputs.
      rst_n = 1'b0; StallM = 1'b0; FlushM = 1'b0;
      apply(mk(4'($urandom), 1'b0, 1'b0, 2'($urandom), 2'($urandom), $urandom, $urandom,
               $urandom, $urandom, $urandom, 1'b0, 3'($urandom), 1'b1, 1'b0, 1'b1,
               1'b0, 0, 0, 0), 7);
      RegWriteE = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_regwrite", {31'b0, RegWriteM}, 0);
      chk("rst_memwrite", {31'b0, MemWriteM}, 0);
      chk("rst_resultsrc", {30'b0, ResultSrcM}, 0);
      chk("rst_alu", ALUResultM, 0);
      chk("rst_wdata", WriteDataM, 0);
      chk("rst_pc4", PCPlus4M, 0);
      chk("rst_rd", {27'b0, RdM}, 0);
      chk("rst_pcsrc_jump", {31'b0, PCSrcE}, 1);
      JumpE = 1'b0;
      #1 chk("rst_pcsrc_nojump", {31'b0, PCSrcE}, 0);

      // alu sa sb fa fb rs1 rs2 pc imm resw br f3 jmp jalr memw | pcsrc tgt alu wd
      vecs.push_back(mk(4'h0,0,0,2'b00,2'b00,32'd5,32'd7,32'h10,32'h8,0,0,3'b000,0,0,0,
                        0,32'h18,32'd12,32'd7));
      vecs.push_back(mk(4'h0,0,0,2'b00,2'b00,32'h100,32'h0,32'h20,32'h0,0,0,3'b000,0,0,0,
                        0,32'h20,32'h100,32'h0));
      vecs.push_back(mk(4'h0,0,1,2'b10,2'b01,32'h0,32'h55,32'h24,32'h4,32'hAB,0,3'b000,0,0,1,
                        0,32'h28,32'h104,32'hAB));
      vecs.push_back(mk(4'h1,0,0,2'b00,2'b00,32'hFFFFFFFF,32'h1,32'h40,32'hFFFFFFF0,0,1,3'b100,
                        0,0,0,1,32'h30,32'hFFFFFFFE,32'h1));
      vecs.push_back(mk(4'h6,0,0,2'b00,2'b00,32'hFFFFFFFF,32'h1,32'h40,32'hFFFFFFF0,0,1,3'b110,
                        0,0,0,0,32'h30,32'h0,32'h1));
      vecs.push_back(mk(4'h5,0,0,2'b00,2'b00,32'hFFFFFFFF,32'h1,32'h40,32'hFFFFFFF0,0,1,3'b010,
                        0,0,0,0,32'h30,32'h1,32'h1));
      vecs.push_back(mk(4'h4,0,0,2'b00,2'b00,32'h9,32'h9,32'h100,32'h20,0,1,3'b000,0,0,0,
                        1,32'h120,32'h0,32'h9));
      vecs.push_back(mk(4'h2,0,0,2'b00,2'b00,32'hFFFFFFFF,32'h1,32'h100,32'h20,0,1,3'b101,0,0,0,
                        0,32'h120,32'h1,32'h1));
      vecs.push_back(mk(4'h3,0,0,2'b00,2'b00,32'hFFFFFFFF,32'h1,32'h100,32'h20,0,1,3'b111,0,0,0,
                        1,32'h120,32'hFFFFFFFF,32'h1));
      vecs.push_back(mk(4'h0,0,1,2'b00,2'b00,32'h1003,32'h77,32'h200,32'h0,0,0,3'b000,1,1,0,
                        1,32'h1002,32'h1003,32'h77));
      vecs.push_back(mk(4'h9,0,0,2'b00,2'b00,32'h80000000,32'd31,0,0,0,0,3'b000,0,0,0,
                        0,32'h0,32'hFFFFFFFF,32'd31));
      vecs.push_back(mk(4'h7,0,0,2'b00,2'b00,32'h3,32'h21,0,0,0,0,3'b000,0,0,0,
                        0,32'h0,32'h6,32'h21));
      vecs.push_back(mk(4'h1,0,0,2'b00,2'b00,32'h0,32'h1,0,0,0,0,3'b000,0,0,0,
                        0,32'h0,32'hFFFFFFFF,32'h1));
      vecs.push_back(mk(4'hC,0,0,2'b00,2'b00,32'h5,32'h6,0,0,0,0,3'b000,0,0,0,
                        0,32'h0,32'h0,32'h6));
      vecs.push_back(mk(4'h8,0,0,2'b00,2'b00,32'h80000000,32'h4,0,0,0,0,3'b000,0,0,0,
                        0,32'h0,32'h08000000,32'h4));
      vecs.push_back(mk(4'hA,1,1,2'b00,2'b11,32'h1,32'h9,32'h300,32'h12345000,0,0,3'b000,0,0,0,
                        0,32'h12345300,32'h12345000,32'h9));
      vecs.push_back(mk(4'h5,0,0,2'b00,2'b10,32'hFFFFFFFF,32'h0,0,0,0,0,3'b000,0,0,0,
                        0,32'h0,32'h1,32'h12345000));
      vecs.push_back(mk(4'h0,1,1,2'b00,2'b00,32'h0,32'h3,32'h1000,32'h10,0,0,3'b000,1,0,0,
                        1,32'h1010,32'h1010,32'h3));

      @(negedge clk);
      rst_n = 1'b1;
      foreach (vecs[i]) begin
         @(negedge clk);
         apply(vecs[i], i);
         #1;
         chk($sformatf("v%0d_pcsrc", i), {31'b0, PCSrcE}, {31'b0, vecs[i].e_pcsrc});
         chk($sformatf("v%0d_target", i), PCTargetE, vecs[i].e_tgt);
         m.regw = i[0]; m.memw = vecs[i].memw; m.rsrc = i[1:0];
         m.alu = vecs[i].e_alu; m.wd = vecs[i].e_wd; m.pc4 = vecs[i].pc + 32'd4;
         m.rd = 5'(i + 1);
         sb_q.push_back(m);
         @(posedge clk);
         #1;
         if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL v%0d_scoreboard: got empty queue expected entry", i);
         end else begin
            m = sb_q.pop_front();
            chk($sformatf("v%0d_alu", i), ALUResultM, m.alu);
            chk($sformatf("v%0d_wdata", i), WriteDataM, m.wd);
            chk($sformatf("v%0d_pc4", i), PCPlus4M, m.pc4);
            chk($sformatf("v%0d_rd", i), {27'b0, RdM}, {27'b0, m.rd});
            chk($sformatf("v%0d_ctl", i), {28'b0, RegWriteM, MemWriteM, ResultSrcM},
                {28'b0, m.regw, m.memw, m.rsrc});
         end
      end

      // Stall: hold for 3 cycles; forwarding from ALUResultM sees the held 0x1010.
      @(negedge clk);
      StallM = 1'b1;
      apply(mk(4'h0,0,1,2'b10,2'b00,32'hDEAD,32'hBEEF,32'h500,32'h2,0,0,3'b000,1,1,1,
               0,0,0,0), 2);
      #1;
      chk("stall_fwd_target", PCTargetE, 32'h1012);
      chk("stall_fwd_pcsrc", {31'b0, PCSrcE}, 1);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("stall%0d_alu", k), ALUResultM, 32'h1010);
         chk($sformatf("stall%0d_rd", k), {27'b0, RdM}, 32'd18);
         chk($sformatf("stall%0d_wdata", k), WriteDataM, 32'h3);
         chk($sformatf("stall%0d_regw", k), {31'b0, RegWriteM}, 1);
         @(negedge clk);
         rs1_data_E = $urandom; rs2_data_E = $urandom;
      end

      // Flush with stall: flush wins.
      FlushM = 1'b1; RegWriteE = 1'b1; RdE = 5'd5;
      @(posedge clk);
      #1;
      chk("flush_regw", {31'b0, RegWriteM}, 0);
      chk("flush_rd", {27'b0, RdM}, 0);
      chk("flush_memw", {31'b0, MemWriteM}, 0);
      chk("flush_alu", ALUResultM, 0);

      // Capture, then asynchronous reset between edges.
      @(negedge clk);
      StallM = 1'b0; FlushM = 1'b0;
      apply(vecs[0], 0);
      @(posedge clk);
      #1 chk("post_flush_alu", ALUResultM, 32'd12);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_alu", ALUResultM, 0);
      chk("async_rst_wdata", WriteDataM, 0);
      chk("async_rst_pc4", PCPlus4M, 0);
      chk("async_rst_rd", {27'b0, RdM}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk("first_capture_alu", ALUResultM, 32'd12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
